imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH_WORDS, default 1024: instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum idle cycles allowed between bytes once a load has started.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 Byte_Valid  input  1  the source presents a byte.
REQ-006 Byte_Data  input  8  byte payload.
REQ-007 Byte_Ready  output  1  the loader accepts a byte; a transfer occurs when Byte_Valid and Byte_Ready are both high on a rising edge.
REQ-008 IMEM_W_En  output  1  one-cycle instruction memory write strobe.
REQ-009 IMEM_W_Addr  output  32  byte address of the word being written; always word-aligned.
REQ-010 IMEM_W_Data  output  32  word being written.
REQ-011 Core_Run  output  1  high releases the pipeline core; low holds it in reset.
REQ-012 Load_Done  output  1  image loaded successfully; sticky.
REQ-013 Load_Error  output  1  load aborted; sticky.

Function
REQ-014 Image format SHALL be: 16-bit word count N, little-endian (2 bytes), followed by N words of 4 bytes each, little-endian.
REQ-015 FSM states SHALL be LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR; the reset state is LEN_LO.
REQ-016 LEN_LO -> LEN_HI on a byte transfer; the byte is captured as count[7:0].
REQ-017 LEN_HI -> DATA on a byte transfer; the byte is captured as count[15:8].
REQ-018 LEN_HI SHALL go to ERROR if the assembled count is 0 or exceeds IMEM_DEPTH_WORDS.
REQ-019 In DATA, byte k of a word (k = 0..3) SHALL land in bits [8k+7:8k]; a 2-bit byte counter wraps 3 -> 0.
REQ-020 On the 4th byte transfer, DATA -> WRITE.
REQ-021 In WRITE, IMEM_W_En SHALL be high for exactly one cycle, with Addr = word_index*4 and the assembled Data.
REQ-022 WRITE latency: the strobe SHALL occur in the cycle after the 4th byte is accepted.
REQ-023 In WRITE, word_index SHALL increment; the next state is DONE if word_index+1 == N, otherwise DATA.
REQ-024 Byte_Ready SHALL be high only in LEN_LO, LEN_HI and DATA; it is low in WRITE, DONE and ERROR (no byte is dropped or accepted during WRITE).
REQ-025 The word_index width is clog2(IMEM_DEPTH_WORDS)+1 bits; Addr is word_index zero-extended and shifted left by 2.
REQ-026 The idle counter SHALL clear on every transfer and increment each cycle in LEN_HI or DATA without a transfer; reaching TIMEOUT_CYCLES -> ERROR.
REQ-027 There is no timeout in LEN_LO: the loader waits indefinitely for a load to start.
REQ-028 DONE: Core_Run = 1 and Load_Done = 1; terminal until reset.
REQ-029 ERROR: Core_Run = 0 and Load_Error = 1; terminal until reset; no further writes.
REQ-030 Core_Run SHALL be registered and glitch-free; it rises in the cycle after the final write strobe.
REQ-031 IMEM_W_Addr and IMEM_W_Data SHALL hold their last values when IMEM_W_En is low.

Reset
REQ-032 While RST = 0, all outputs SHALL be 0: Byte_Ready, IMEM_W_En, IMEM_W_Addr, IMEM_W_Data, Core_Run, Load_Done, Load_Error.
REQ-033 Reset assertion mid-load (any state) SHALL immediately abort the load, drop Core_Run, and clear the byte, word and idle counters.
REQ-034 After reset, state SHALL be LEN_LO; Byte_Ready rises in the first clock after RST deasserts.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (loader_state_t) and the image header width constant (LEN_BYTES = 2).
REQ-036 One sub-module SHALL be natural: byte_assembler (shift-in of 4 bytes into a word, with a word-complete flag); all other logic stays flat.
REQ-037 Core integration SHALL drive the core's reset from Core_Run and the instruction memory write port from IMEM_W_*.

Verification
REQ-038 Normal load: count 0x0002, bytes 13 05 00 00, 93 00 10 00 -> writes (0x0, 0x00000513) and (0x4, 0x00100093); Core_Run = 1 one cycle after the 2nd strobe.
REQ-039 Zero count: bytes 00 00 -> Load_Error = 1, no IMEM_W_En pulse, Core_Run stays 0.
REQ-040 Oversize: IMEM_DEPTH_WORDS = 4, count 0x0005 -> ERROR after the 2nd byte; Byte_Ready = 0 thereafter.
REQ-041 Timeout: TIMEOUT_CYCLES = 8, count 1, then 2 bytes, then Byte_Valid = 0 for 8 cycles -> Load_Error = 1, no write.
REQ-042 Backpressure: Byte_Valid held high continuously -> Byte_Ready = 0 in each WRITE cycle, every byte consumed exactly once, data is correct.
REQ-043 Reset mid-load: RST pulsed low after 3 of 4 data bytes -> all outputs 0; a full reload then succeeds from address 0x0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states and image header size.
package imem_loader_pkg;

  localparam int LEN_BYTES = 2;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; o_word/o_cmplt are valid
// combinationally in the cycle the 4th byte of a word is presented.
module imem_loader_byte_assembler (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vld,
  input  logic [7:0]  i_dat,
  output logic [31:0] o_word,
  output logic        o_cmplt
);

  logic [1:0]  r_cnt;
  // Holds the three earlier bytes of the current word, oldest in the low bits.
  logic [23:0] r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= 2'd0;
      r_shift <= 24'd0;
    end else if (i_vld) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_dat, r_shift[23:8]};
    end
  end

  assign o_word  = {i_dat, r_shift};
  assign o_cmplt = i_vld && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed word image over a valid/ready byte stream,
// writes it to instruction memory, then releases the core (or flags an error).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH_WORDS = 1024,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Byte_Valid,
  input  logic [7:0]  Byte_Data,
  output logic        Byte_Ready,
  output logic        IMEM_W_En,
  output logic [31:0] IMEM_W_Addr,
  output logic [31:0] IMEM_W_Data,
  output logic        Core_Run,
  output logic        Load_Done,
  output logic        Load_Error
);

  localparam int          LEN_W   = LEN_BYTES * 8;
  localparam int          IDX_W   = $clog2(IMEM_DEPTH_WORDS) + 1;
  localparam int          IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] DEPTH_U = 32'(IMEM_DEPTH_WORDS);

  loader_state_t     r_state, w_next;
  logic              r_ready, r_w_en, r_run, r_done, r_err;
  logic [31:0]       r_w_addr, r_w_data;
  logic [LEN_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_widx;
  logic [IDLE_W-1:0] r_idle;

  logic              w_xfer, w_asm_vld, w_cmplt, w_idle_cnt, w_timeout;
  logic [LEN_W-1:0]  w_len;
  logic [IDX_W-1:0]  w_widx_inc;
  logic [31:0]       w_word;

  assign w_xfer     = Byte_Valid && r_ready;
  assign w_asm_vld  = w_xfer && (r_state == DATA);
  assign w_len      = {Byte_Data, r_count[7:0]};
  assign w_widx_inc = r_widx + IDX_W'(1);
  assign w_idle_cnt = !w_xfer && ((r_state == LEN_HI) || (r_state == DATA));
  assign w_timeout  = w_idle_cnt && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  imem_loader_byte_assembler u_asm (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_vld   (w_asm_vld),
    .i_dat   (Byte_Data),
    .o_word  (w_word),
    .o_cmplt (w_cmplt)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      LEN_LO: if (w_xfer) w_next = LEN_HI;
      LEN_HI: begin
        if (w_xfer) begin
          if ((w_len == '0) || (32'(w_len) > DEPTH_U)) w_next = ERROR;
          else                                         w_next = DATA;
        end else if (w_timeout) begin
          w_next = ERROR;
        end
      end
      DATA: begin
        if (w_cmplt)        w_next = WRITE;
        else if (w_timeout) w_next = ERROR;
      end
      WRITE: w_next = (32'(w_widx_inc) == 32'(r_count)) ? DONE : DATA;
      DONE:  w_next = DONE;
      ERROR: w_next = ERROR;
      default: w_next = ERROR;
    endcase
  end

  // Status outputs are decoded from the next state so they are clean flops that
  // line up with the state register (ready low in WRITE, run high in DONE).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= LEN_LO;
      r_ready <= 1'b0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == LEN_LO) || (w_next == LEN_HI) || (w_next == DATA);
      r_run   <= (w_next == DONE);
      r_done  <= (w_next == DONE);
      r_err   <= (w_next == ERROR);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= '0;
      r_idle  <= '0;
      r_widx  <= '0;
    end else begin
      if (w_xfer && (r_state == LEN_LO)) r_count[7:0]       <= Byte_Data;
      if (w_xfer && (r_state == LEN_HI)) r_count[LEN_W-1:8] <= Byte_Data;
      if (w_xfer)          r_idle <= '0;
      else if (w_idle_cnt) r_idle <= r_idle + IDLE_W'(1);
      if (r_state == WRITE) r_widx <= w_widx_inc;
    end
  end

  // Address/data load with the strobe and hold between writes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_w_en   <= 1'b0;
      r_w_addr <= 32'd0;
      r_w_data <= 32'd0;
    end else begin
      r_w_en <= w_cmplt;
      if (w_cmplt) begin
        r_w_addr <= 32'(r_widx) << 2;
        r_w_data <= w_word;
      end
    end
  end

  assign Byte_Ready  = r_ready;
  assign IMEM_W_En   = r_w_en;
  assign IMEM_W_Addr = r_w_addr;
  assign IMEM_W_Data = r_w_data;
  assign Core_Run    = r_run;
  assign Load_Done   = r_done;
  assign Load_Error  = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time, popped on strobes.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Byte_Valid = 1'b0;
  logic [7:0]  Byte_Data = 8'h00;
  logic        Byte_Ready, IMEM_W_En, Core_Run, Load_Done, Load_Error;
  logic [31:0] IMEM_W_Addr, IMEM_W_Data;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 CLK = ~CLK;

  imem_loader #(.IMEM_DEPTH_WORDS(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Byte_Valid  (Byte_Valid),
    .Byte_Data   (Byte_Data),
    .Byte_Ready  (Byte_Ready),
    .IMEM_W_En   (IMEM_W_En),
    .IMEM_W_Addr (IMEM_W_Addr),
    .IMEM_W_Data (IMEM_W_Data),
    .Core_Run    (Core_Run),
    .Load_Done   (Load_Done),
    .Load_Error  (Load_Error)
  );

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (IMEM_W_En) begin
      wr_t w;
      n_cmp++;
      if (Byte_Ready !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_in_write: Byte_Ready=%0b required 0", Byte_Ready);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write required", IMEM_W_Addr, IMEM_W_Data);
      end else begin
        w = exp_q.pop_front();
        if ({IMEM_W_Addr, IMEM_W_Data} !== {w.addr, w.data}) begin
          n_bad++;
          $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                   IMEM_W_Addr, IMEM_W_Data, w.addr, w.data);
        end
      end
    end
  end

  task automatic do_reset();
    Byte_Valid = 1'b0;
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    Byte_Valid = 1'b1;
    Byte_Data  = b;
    while (!Byte_Ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL byte_accept: Byte_Ready=0 for %0d cycles, required 1", n);
    end
    @(negedge CLK);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!Load_Done && n < 60) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (Load_Done !== 1'b1 || Core_Run !== 1'b1 || Load_Error !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: done=%0b run=%0b err=%0b required 1 1 0", tag, Load_Done, Core_Run, Load_Error);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending: %0d writes missing, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({Byte_Ready, IMEM_W_En, Core_Run, Load_Done, Load_Error} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: rdy/we/run/done/err=%b required 00000",
               {Byte_Ready, IMEM_W_En, Core_Run, Load_Done, Load_Error});
    end
    n_cmp++;
    if (IMEM_W_Addr !== 32'd0 || IMEM_W_Data !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_bus: addr=%h data=%h required 0 0", IMEM_W_Addr, IMEM_W_Data);
    end
    RST = 1'b1;
    #1;
    n_cmp++;
    if (Byte_Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_before_clk: Byte_Ready=%0b required 0", Byte_Ready);
    end
    @(negedge CLK);
    n_cmp++;
    if (Byte_Ready !== 1'b1 || Core_Run !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_after_clk: rdy=%0b run=%0b required 1 0", Byte_Ready, Core_Run);
    end
  endtask

  task automatic test_normal();
    logic [7:0] img [10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00};
    do_reset();
    exp_q.push_back('{addr: 32'h0, data: 32'h00000513});
    exp_q.push_back('{addr: 32'h4, data: 32'h00100093});
    foreach (img[i]) send_byte(img[i]);
    Byte_Valid = 1'b0;
    n_cmp++;
    if (IMEM_W_En !== 1'b1 || Core_Run !== 1'b0) begin
      n_bad++;
      $display("FAIL normal_last_strobe: we=%0b run=%0b required 1 0", IMEM_W_En, Core_Run);
    end
    @(negedge CLK);
    n_cmp++;
    if (Core_Run !== 1'b1 || Load_Done !== 1'b1 || IMEM_W_En !== 1'b0 || Byte_Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL normal_run: run=%0b done=%0b we=%0b rdy=%0b required 1 1 0 0",
               Core_Run, Load_Done, IMEM_W_En, Byte_Ready);
    end
    n_cmp++;
    if (IMEM_W_Addr !== 32'h4 || IMEM_W_Data !== 32'h00100093) begin
      n_bad++;
      $display("FAIL normal_hold: addr=%h data=%h required 00000004 00100093", IMEM_W_Addr, IMEM_W_Data);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL normal_pending: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    Byte_Valid = 1'b0;
    n_cmp++;
    if (Load_Error !== 1'b1 || Byte_Ready !== 1'b0 || Core_Run !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_err: err=%0b rdy=%0b run=%0b required 1 0 0", Load_Error, Byte_Ready, Core_Run);
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (Load_Error !== 1'b1 || Load_Done !== 1'b0 || Core_Run !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_sticky: err=%0b done=%0b run=%0b required 1 0 0", Load_Error, Load_Done, Core_Run);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h05);
    send_byte(8'h00);
    Byte_Data = 8'hFF;
    n_cmp++;
    if (Load_Error !== 1'b1 || Byte_Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL oversize_err: err=%0b rdy=%0b required 1 0", Load_Error, Byte_Ready);
    end
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (Byte_Ready !== 1'b0 || Load_Error !== 1'b1 || Core_Run !== 1'b0) begin
      n_bad++;
      $display("FAIL oversize_hold: rdy=%0b err=%0b run=%0b required 0 1 0", Byte_Ready, Load_Error, Core_Run);
    end
    Byte_Valid = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    Byte_Valid = 1'b0;
    repeat (7) @(negedge CLK);
    n_cmp++;
    if (Load_Error !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_early: err=%0b after 7 idle cycles, required 0", Load_Error);
    end
    @(negedge CLK);
    n_cmp++;
    if (Load_Error !== 1'b1 || Byte_Ready !== 1'b0 || Core_Run !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_err: err=%0b rdy=%0b run=%0b required 1 0 0", Load_Error, Byte_Ready, Core_Run);
    end
  endtask

  // Full-depth image with Byte_Valid never dropped, exercising WRITE-cycle stalls.
  task automatic test_back_to_back();
    logic [31:0] words [4];
    do_reset();
    foreach (words[i]) begin
      words[i] = $urandom;
      exp_q.push_back('{addr: 32'(i) << 2, data: words[i]});
    end
    send_byte(8'h04);
    send_byte(8'h00);
    foreach (words[i]) begin
      logic [31:0] w;
      w = words[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    end
    Byte_Valid = 1'b0;
    wait_done("b2b");
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    Byte_Valid = 1'b0;
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({Byte_Ready, IMEM_W_En, Core_Run, Load_Done, Load_Error} !== 5'b0 ||
        IMEM_W_Addr !== 32'd0 || IMEM_W_Data !== 32'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: flags=%b addr=%h data=%h required all 0",
               {Byte_Ready, IMEM_W_En, Core_Run, Load_Done, Load_Error}, IMEM_W_Addr, IMEM_W_Data);
    end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    exp_q.push_back('{addr: 32'h0, data: 32'hCAFEF00D});
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h0D);
    send_byte(8'hF0);
    send_byte(8'hFE);
    send_byte(8'hCA);
    Byte_Valid = 1'b0;
    wait_done("reload");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_count();
    test_oversize();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
